// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : router_ctrl
//  Description : Sequencing controller for the 1x3 router. Decodes the header
//                address, runs the packet-load state machine, steers writes
//                into one of three destination FIFOs, and generates the
//                per-destination valid and soft-reset (read timeout) signals.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   sole clock, rising edge
//    resetn         in   asynchronous active-low reset
//    pkt_valid      in   source packet valid
//    data_in[1:0]   in   header address, sampled in DECODE_ADDRESS
//    parity_done    in   parity byte captured (register block)
//    low_pkt_valid  in   pkt_valid fell while a FIFO was full (register block)
//    fifo_full[2:0] in   per-destination FIFO full
//    fifo_empty[2:0]in   per-destination FIFO empty
//    read_enb[2:0]  in   per-destination read enable from the sink
//    busy           out  source must hold data_in
//    detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                   out  one-hot state strobes to the register block
//    write_enb[2:0] out  one-hot FIFO write enable
//    dest_full      out  full flag of the selected destination
//    valid_out[2:0] out  per-destination data available
//    soft_reset[2:0]out  per-destination FIFO flush pulse
// ============================================================================
module router_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic [2:0] write_enb,
    output logic       dest_full,
    output logic [2:0] valid_out,
    output logic [2:0] soft_reset
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_DECODE_ADDRESS     = 3'd0;
    localparam logic [2:0] c_LOAD_FIRST_DATA    = 3'd1;
    localparam logic [2:0] c_LOAD_DATA          = 3'd2;
    localparam logic [2:0] c_FIFO_FULL_STATE    = 3'd3;
    localparam logic [2:0] c_LOAD_AFTER_FULL    = 3'd4;
    localparam logic [2:0] c_LOAD_PARITY        = 3'd5;
    localparam logic [2:0] c_CHECK_PARITY_ERROR = 3'd6;
    localparam logic [2:0] c_WAIT_TILL_EMPTY    = 3'd7;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_addr;

    logic       w_in_empty;    // fifo_empty selected by the incoming header
    logic       w_addr_empty;  // fifo_empty selected by the latched address
    logic       w_addr_soft;   // soft_reset selected by the latched address
    logic       w_dest_full;
    logic [2:0] w_addr_onehot;

    // ------------------------------------------------------------------------
    // Destination selection. Address 3 is not a destination, so every
    // selector returns 0 for it instead of indexing past the 3-bit vectors.
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_empty = 1'b0;
        case (data_in)
            2'd0:    w_in_empty = fifo_empty[0];
            2'd1:    w_in_empty = fifo_empty[1];
            2'd2:    w_in_empty = fifo_empty[2];
            default: w_in_empty = 1'b0;
        endcase
    end

    always_comb begin
        w_addr_empty  = 1'b0;
        w_addr_soft   = 1'b0;
        w_dest_full   = 1'b0;
        w_addr_onehot = 3'b000;
        case (r_addr)
            2'd0: begin
                w_addr_empty  = fifo_empty[0];
                w_addr_soft   = soft_reset[0];
                w_dest_full   = fifo_full[0];
                w_addr_onehot = 3'b001;
            end
            2'd1: begin
                w_addr_empty  = fifo_empty[1];
                w_addr_soft   = soft_reset[1];
                w_dest_full   = fifo_full[1];
                w_addr_onehot = 3'b010;
            end
            2'd2: begin
                w_addr_empty  = fifo_empty[2];
                w_addr_soft   = soft_reset[2];
                w_dest_full   = fifo_full[2];
                w_addr_onehot = 3'b100;
            end
            default: begin
                w_addr_empty  = 1'b0;
                w_addr_soft   = 1'b0;
                w_dest_full   = 1'b0;
                w_addr_onehot = 3'b000;
            end
        endcase
    end

    assign dest_full = w_dest_full;
    assign valid_out = ~fifo_empty;

    // ------------------------------------------------------------------------
    // Header address register: follows data_in for as long as the FSM sits
    // in DECODE_ADDRESS with a valid packet, so it holds the header value
    // once the FSM leaves that state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr <= 2'd0;
        end else if (r_state == c_DECODE_ADDRESS && pkt_valid) begin
            r_addr <= data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Packet-load state machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (r_state != c_DECODE_ADDRESS && w_addr_soft) begin
            // A flushed destination abandons the packet in any loading state.
            w_next_state = c_DECODE_ADDRESS;
        end else begin
            case (r_state)
                c_DECODE_ADDRESS: begin
                    if (pkt_valid && data_in != 2'd3) begin
                        w_next_state = w_in_empty ? c_LOAD_FIRST_DATA
                                                  : c_WAIT_TILL_EMPTY;
                    end
                end
                c_LOAD_FIRST_DATA: begin
                    w_next_state = c_LOAD_DATA;
                end
                c_LOAD_DATA: begin
                    if (w_dest_full) begin
                        w_next_state = c_FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        w_next_state = c_LOAD_PARITY;
                    end
                end
                c_FIFO_FULL_STATE: begin
                    if (!w_dest_full) begin
                        w_next_state = c_LOAD_AFTER_FULL;
                    end
                end
                c_LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        w_next_state = c_DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        w_next_state = c_LOAD_PARITY;
                    end else begin
                        w_next_state = c_LOAD_DATA;
                    end
                end
                c_LOAD_PARITY: begin
                    w_next_state = c_CHECK_PARITY_ERROR;
                end
                c_CHECK_PARITY_ERROR: begin
                    w_next_state = w_dest_full ? c_FIFO_FULL_STATE
                                               : c_DECODE_ADDRESS;
                end
                c_WAIT_TILL_EMPTY: begin
                    if (w_addr_empty) begin
                        w_next_state = c_LOAD_FIRST_DATA;
                    end
                end
                default: begin
                    w_next_state = c_DECODE_ADDRESS;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_DECODE_ADDRESS;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------------
    assign detect_add  = (r_state == c_DECODE_ADDRESS);
    assign lfd_state   = (r_state == c_LOAD_FIRST_DATA);
    assign ld_state    = (r_state == c_LOAD_DATA);
    assign laf_state   = (r_state == c_LOAD_AFTER_FULL);
    assign full_state  = (r_state == c_FIFO_FULL_STATE);
    assign rst_int_reg = (r_state == c_CHECK_PARITY_ERROR);

    // The source may only present new bytes while decoding or streaming.
    assign busy = !(r_state == c_DECODE_ADDRESS || r_state == c_LOAD_DATA);

    assign write_enb = (r_state == c_LOAD_DATA       ||
                        r_state == c_LOAD_PARITY     ||
                        r_state == c_LOAD_AFTER_FULL) ? w_addr_onehot : 3'b000;

    // ------------------------------------------------------------------------
    // Read timeout, one independent counter per destination. The counter
    // counts consecutive cycles in which the FIFO holds data but the sink is
    // not reading. On the TIMEOUT-th such cycle it wraps to zero and fires a
    // single-cycle soft_reset, so a persistently ignored FIFO is flushed
    // once every TIMEOUT cycles.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_timeout
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_pulse;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else if (fifo_empty[gi] || read_enb[gi]) begin
                r_cnt   <= '0;
                r_pulse <= 1'b0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_cnt   <= '0;
                r_pulse <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_pulse <= 1'b0;
            end
        end

        assign soft_reset[gi] = r_pulse;
    end

endmodule
`default_nettype wire

// File: tb/tb_router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_ctrl
//  Description : Directed self-checking bench for router_ctrl (TIMEOUT = 30).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_ctrl;

    // Expected strobe patterns, ordered
    // {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy}
    localparam logic [6:0] c_S_DEC  = 7'b1000000;
    localparam logic [6:0] c_S_LFD  = 7'b0100001;
    localparam logic [6:0] c_S_LD   = 7'b0010000;
    localparam logic [6:0] c_S_LAF  = 7'b0001001;
    localparam logic [6:0] c_S_FULL = 7'b0000101;
    localparam logic [6:0] c_S_CP   = 7'b0000011;
    localparam logic [6:0] c_S_LP   = 7'b0000001;
    localparam logic [6:0] c_S_WAIT = 7'b0000001;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [2:0] write_enb;
    logic       dest_full;
    logic [2:0] valid_out;
    logic [2:0] soft_reset;

    int n_checks = 0;
    int n_errors = 0;

    router_ctrl #(.TIMEOUT(30)) u_dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .read_enb      (read_enb),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb     (write_enb),
        .dest_full     (dest_full),
        .valid_out     (valid_out),
        .soft_reset    (soft_reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobes, busy and write_enb packed as {pattern, write_enb}
    function automatic logic [31:0] outs();
        return {22'd0, detect_add, lfd_state, ld_state, laf_state,
                full_state, rst_int_reg, busy, write_enb};
    endfunction

    function automatic logic [31:0] ex(input logic [6:0] s, input logic [2:0] we);
        return {22'd0, s, we};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic defaults();
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        fifo_full     = 3'b000;
        fifo_empty    = 3'b111;
        read_enb      = 3'b000;
    endtask

    task automatic do_reset();
        defaults();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        defaults();
        resetn = 1'b1;

        // ---------------- reset values ----------------
        #1;
        resetn     = 1'b0;
        fifo_full  = 3'b001;
        fifo_empty = 3'b101;
        #1;
        check("rst_outs",   outs(), ex(c_S_DEC, 3'b000));
        check("rst_soft",   {29'd0, soft_reset}, 32'd0);
        check("rst_valid",  {29'd0, valid_out}, 32'h2);
        check("rst_dfull",  {31'd0, dest_full}, 32'h1);
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        tick();
        resetn = 1'b1;

        // ---------------- normal packet to dest 2 ----------------
        pkt_valid = 1'b1;
        data_in   = 2'd2;
        tick(); check("np_lfd", outs(), ex(c_S_LFD, 3'b000));
        tick(); check("np_ld1", outs(), ex(c_S_LD,  3'b100));
        tick(); check("np_ld2", outs(), ex(c_S_LD,  3'b100));
        tick(); check("np_ld3", outs(), ex(c_S_LD,  3'b100));
        pkt_valid = 1'b0;
        tick(); check("np_lp",  outs(), ex(c_S_LP,  3'b100));
        tick(); check("np_cp",  outs(), ex(c_S_CP,  3'b000));
        tick(); check("np_dec", outs(), ex(c_S_DEC, 3'b000));

        // ---------------- address 3 dropped ----------------
        pkt_valid = 1'b1;
        data_in   = 2'd3;
        fifo_full = 3'b111;
        tick(); check("a3_dec1", outs(), ex(c_S_DEC, 3'b000));
        check("a3_dfull", {31'd0, dest_full}, 32'd0);
        tick(); check("a3_dec2", outs(), ex(c_S_DEC, 3'b000));
        pkt_valid = 1'b0;
        fifo_full = 3'b000;

        // ---------------- destination busy ----------------
        pkt_valid  = 1'b1;
        data_in    = 2'd0;
        fifo_empty = 3'b110;
        tick(); check("wt_wait1", outs(), ex(c_S_WAIT, 3'b000));
        pkt_valid = 1'b0;
        tick(); check("wt_wait2", outs(), ex(c_S_WAIT, 3'b000));
        fifo_empty = 3'b111;
        tick(); check("wt_lfd",   outs(), ex(c_S_LFD, 3'b000));
        tick(); check("wt_ld",    outs(), ex(c_S_LD,  3'b001));
        tick(); check("wt_lp",    outs(), ex(c_S_LP,  3'b001));

        // ---------------- FIFO full handling, dest 1 ----------------
        do_reset();
        pkt_valid = 1'b1;
        data_in   = 2'd1;
        tick(); check("ff_lfd", outs(), ex(c_S_LFD, 3'b000));
        tick(); check("ff_ld",  outs(), ex(c_S_LD,  3'b010));
        fifo_full = 3'b010;
        pkt_valid = 1'b0;   // full must win over the end of packet
        #1;
        check("ff_dfull", {31'd0, dest_full}, 32'h1);
        tick(); check("ff_full1", outs(), ex(c_S_FULL, 3'b000));
        tick(); check("ff_full2", outs(), ex(c_S_FULL, 3'b000));
        fifo_full = 3'b000;
        tick(); check("ff_laf",   outs(), ex(c_S_LAF, 3'b010));
        low_pkt_valid = 1'b1;
        tick(); check("ff_lp",    outs(), ex(c_S_LP,  3'b010));
        low_pkt_valid = 1'b0;
        fifo_full     = 3'b010;
        tick(); check("ff_cp",    outs(), ex(c_S_CP,  3'b000));
        tick(); check("ff_cpfull", outs(), ex(c_S_FULL, 3'b000));
        fifo_full = 3'b000;
        tick(); check("ff_laf2",  outs(), ex(c_S_LAF, 3'b010));
        parity_done   = 1'b1;   // parity_done must win over low_pkt_valid
        low_pkt_valid = 1'b1;
        tick(); check("ff_pdone", outs(), ex(c_S_DEC, 3'b000));
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;

        // ---------------- reset mid-packet ----------------
        pkt_valid = 1'b1;
        data_in   = 2'd1;
        tick(); check("mr_lfd", outs(), ex(c_S_LFD, 3'b000));
        tick(); check("mr_ld",  outs(), ex(c_S_LD,  3'b010));
        resetn = 1'b0;
        #1;
        check("mr_async", outs(), ex(c_S_DEC, 3'b000));
        check("mr_soft",  {29'd0, soft_reset}, 32'd0);
        tick(); check("mr_held", outs(), ex(c_S_DEC, 3'b000));
        resetn    = 1'b1;
        pkt_valid = 1'b0;

        // ---------------- timeout on dest 0 ----------------
        fifo_empty = 3'b110;
        #1;
        check("to_valid", {29'd0, valid_out}, 32'h1);
        for (int i = 1; i <= 29; i++) tick();
        check("to_pre",   {29'd0, soft_reset}, 32'd0);
        tick(); check("to_pulse", {29'd0, soft_reset}, 32'h1);
        tick(); check("to_once",  {29'd0, soft_reset}, 32'd0);
        fifo_empty = 3'b111;
        tick();

        // read on the 29th sample suppresses the pulse
        fifo_empty = 3'b110;
        for (int i = 1; i <= 28; i++) tick();
        read_enb = 3'b001;
        tick();
        read_enb = 3'b000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("to_supp", {29'd0, soft_reset}, 32'd0);
        end
        fifo_empty = 3'b111;
        tick();

        // ---------------- timeout aborts WAIT_TILL_EMPTY ----------------
        do_reset();
        pkt_valid  = 1'b1;
        data_in    = 2'd0;
        fifo_empty = 3'b110;
        tick(); check("ab_wait", outs(), ex(c_S_WAIT, 3'b000));
        pkt_valid = 1'b0;
        for (int i = 2; i <= 29; i++) tick();
        check("ab_nosoft", {29'd0, soft_reset}, 32'd0);
        tick();
        check("ab_pulse", {29'd0, soft_reset}, 32'h1);
        check("ab_still", outs(), ex(c_S_WAIT, 3'b000));
        tick();
        check("ab_dec",   outs(), ex(c_S_DEC, 3'b000));
        check("ab_soft0", {29'd0, soft_reset}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_ctrl.md
# router_ctrl

Sequencing controller for the 1x3 router. It decodes the header address, owns the packet-load state machine, and steers writes into one of three destination FIFOs. It also generates per-destination `valid_out` and the soft-reset timeout that flushes a FIFO nobody is reading. It sits between the source-side register block (header hold, parity) and the three output FIFOs.

## Interface
Parameters:
- `TIMEOUT`, default 30: consecutive unread cycles before a destination is soft-reset. Minimum 2.

Ports:
- `clock` in 1: sole clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pkt_valid` in 1: source packet valid.
- `data_in` in 2: header address bits [1:0]. Sampled only in DECODE_ADDRESS.
- `parity_done` in 1: parity byte captured, from the register block.
- `low_pkt_valid` in 1: `pkt_valid` fell while a FIFO was full, from the register block.
- `fifo_full` in 3: per-destination FIFO full.
- `fifo_empty` in 3: per-destination FIFO empty.
- `read_enb` in 3: per-destination read enable from the sink.
- `busy` out 1: tells the source to hold `data_in`.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` out 1 each: state strobes to the register block.
- `write_enb` out 3: one-hot FIFO write enable.
- `dest_full` out 1: `fifo_full[addr_q]`, or 0 when `addr_q` is 3.
- `valid_out` out 3: per-destination data available.
- `soft_reset` out 3: per-destination FIFO flush pulse.

## Operation
- **Address register.** `addr_q` (2 bits) loads `data_in` on every clock while in DECODE_ADDRESS with `pkt_valid`=1.
- **FSM states and transitions.** Registered, Moore outputs. Evaluate in this priority order:
  - **Soft-reset abort (all states except DECODE_ADDRESS).** If `soft_reset[addr_q]`=1, go to DECODE_ADDRESS.
  - **DECODE_ADDRESS.** Requires `pkt_valid`=1 and `data_in`≠3.
    - `fifo_empty[data_in]`=1: go to LOAD_FIRST_DATA.
    - `fifo_empty[data_in]`=0: go to WAIT_TILL_EMPTY.
    - Otherwise stay. Address 3 is dropped.
  - **LOAD_FIRST_DATA.** Go to LOAD_DATA.
  - **LOAD_DATA.**
    - `dest_full`=1: go to FIFO_FULL_STATE.
    - Else `pkt_valid`=0: go to LOAD_PARITY.
    - Else stay.
  - **FIFO_FULL_STATE.** `dest_full`=0: go to LOAD_AFTER_FULL. Else stay.
  - **LOAD_AFTER_FULL.**
    - `parity_done`=1: go to DECODE_ADDRESS.
    - Else `low_pkt_valid`=1: go to LOAD_PARITY.
    - Else go to LOAD_DATA.
  - **LOAD_PARITY.** Go to CHECK_PARITY_ERROR.
  - **CHECK_PARITY_ERROR.** `dest_full`=1: go to FIFO_FULL_STATE. Else go to DECODE_ADDRESS.
  - **WAIT_TILL_EMPTY.** `fifo_empty[addr_q]`=1: go to LOAD_FIRST_DATA. Else stay.
- **State strobes.** Each strobe is 1 in exactly one state:
  - `detect_add`: DECODE_ADDRESS.
  - `lfd_state`: LOAD_FIRST_DATA.
  - `ld_state`: LOAD_DATA.
  - `laf_state`: LOAD_AFTER_FULL.
  - `full_state`: FIFO_FULL_STATE.
  - `rst_int_reg`: CHECK_PARITY_ERROR.
- **busy.** 0 in DECODE_ADDRESS and LOAD_DATA, 1 in every other state.
- **write_enb.** Equals `(1 << addr_q)` in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL, else 3'b000. Always one-hot or zero.
- **valid_out.** `valid_out[i]` = `~fifo_empty[i]`. Combinational.
- **Timeout counters.** One per destination, width `$clog2(TIMEOUT)`.
  - Cleared when `valid_out[i]`=0 or `read_enb[i]`=1.
  - Otherwise incremented.
  - On the edge where the count is TIMEOUT-1 and the condition still holds: `soft_reset[i]`<=1 and the count<=0.
  - `soft_reset[i]` is registered and high for exactly one cycle per timeout.
  - Counters run independently of FSM state.

## Timing
- **Reset (asynchronous assertion).**
  - State DECODE_ADDRESS, `addr_q`=0, all counters 0, `soft_reset`=0.
  - Outputs during reset: `detect_add`=1, `busy`=0, other strobes 0, `write_enb`=0. `valid_out` and `dest_full` follow their inputs.
  - Reset asserted mid-packet forces these values immediately.
  - First transition is possible on the first rising edge after `resetn` deasserts.
- **Latency.** All strobes, `busy` and `write_enb` change one cycle after the qualifying input is sampled.
- **Soft-reset timing.**
  - `soft_reset[i]` rises one cycle after the TIMEOUT-th consecutive qualifying sample.
  - A `read_enb[i]` pulse on any cycle up to and including the TIMEOUT-th sample suppresses the pulse.
  - Holding the condition produces a pulse every TIMEOUT cycles.
  - The FSM abort takes effect on the edge following the `soft_reset` pulse.
- **Simultaneous events.**
  - Soft-reset abort beats every other transition.
  - `dest_full` beats `pkt_valid`=0 in LOAD_DATA.
  - `parity_done` beats `low_pkt_valid` in LOAD_AFTER_FULL.

## Test plan
- **Reset mid-packet.** Pull `resetn` low while in LOAD_DATA for dest 1 → immediately `write_enb`=000, `busy`=0, `detect_add`=1, `soft_reset`=000.
- **Normal packet.** Header address 2 with `fifo_empty`=111, `pkt_valid` high 3 cycles then low → states DECODE, LFD, LOAD_DATA×3, LOAD_PARITY, CHECK_PARITY, DECODE. `write_enb`=100 for 4 cycles. `busy`=1 only in LFD, LOAD_PARITY and CHECK_PARITY.
- **Destination busy.** Header address 0 with `fifo_empty[0]`=0 → WAIT_TILL_EMPTY, `busy`=1, `write_enb`=000. Raise `fifo_empty[0]` → LFD next cycle.
- **FIFO full.** `fifo_full[1]`=1 in LOAD_DATA for dest 1 → FIFO_FULL_STATE, `write_enb`=000, `full_state`=1. Drop full → LOAD_AFTER_FULL. With `parity_done`=0 and `low_pkt_valid`=1 → LOAD_PARITY.
- **Timeout.**
  - `fifo_empty[0]`=0 and `read_enb[0]`=0 held 30 cycles (TIMEOUT=30) → single `soft_reset[0]` pulse on cycle 31.
  - Repeat with `read_enb[0]`=1 on cycle 29 → no pulse.
  - FSM in WAIT_TILL_EMPTY for dest 0 → back in DECODE the cycle after the pulse.
- **Address 3.** Header address 3 with `pkt_valid`=1 → FSM stays DECODE_ADDRESS, `write_enb`=000, `busy`=0.
